// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: aligns captured pixel streams to start-of-frame,
// generates linear row-major frame-buffer write addresses and reports frame
// completion / short-frame restarts. Upstream is never back-pressured; beats
// that are not captured are simply dropped.
module frame_capture_ctrl #(
    parameter int DW     = 12,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int AW     = 19
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_mode,
    input  logic          i_snap,
    input  logic          i_data_valid,
    input  logic          i_sof,
    input  logic [DW-1:0] i_data,
    output logic          o_data_ready,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [DW-1:0] o_wr_data,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic          o_err_short,
    output logic [7:0]    o_frame_cnt
);

    // Address of the final pixel of a frame (WIDTH*HEIGHT is assumed >= 2).
    localparam logic [AW-1:0] LAST_ADDR = AW'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_SOF = 2'd1,
        S_CAPTURE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_d;
    logic [AW-1:0] addr_d;
    logic          done_d;
    logic          err_d;
    logic          beat_acc;
    logic          mode_cont;
    logic          mode_active;

    assign beat_acc    = i_data_valid & o_data_ready;
    assign mode_cont   = (i_mode == 2'b01);
    // Single mode keeps an armed capture waiting for SOF; stop/11 abandons it.
    assign mode_active = (i_mode == 2'b01) || (i_mode == 2'b10);

    // State, address counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            o_data_ready <= 1'b0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err_short  <= 1'b0;
            o_frame_cnt  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_data_ready <= 1'b1;
            o_wr_en      <= wr_d;
            o_wr_addr    <= addr_d;
            o_wr_data    <= wr_d ? i_data : '0;
            o_busy       <= (state_d != S_IDLE);
            o_frame_done <= done_d;
            o_err_short  <= err_d;
            o_frame_cnt  <= o_frame_cnt + {7'd0, done_d};
        end
    end

    // Next state, next counter and the write/pulse decisions for this beat.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = 1'b0;
        addr_d  = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mode_cont || (i_mode == 2'b10 && i_snap))
                    state_d = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                // A SOF beat wins even if the mode drops in the same cycle.
                if (beat_acc && i_sof) begin
                    wr_d    = 1'b1;
                    cnt_d   = AW'(1);
                    state_d = S_CAPTURE;
                end else if (!mode_active) begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (beat_acc) begin
                    wr_d = 1'b1;
                    if (i_sof) begin
                        // Short frame: restart at 0 without counting a frame.
                        err_d = 1'b1;
                        cnt_d = AW'(1);
                    end else begin
                        addr_d = cnt_q;
                        if (cnt_q == LAST_ADDR) begin
                            done_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = mode_cont ? S_WAIT_SOF : S_IDLE;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
- Sequences writes of processed pixels from the video-processing stage into the frame buffer's write port.
- Aligns every capture to a start-of-frame beat and generates linear write addresses.
- Supports three modes: stop/freeze, continuous capture, and single-frame snapshot.
- Sits between the video-processing output handshake and the frame memory in the i_clk domain. It keeps the displayed frame untorn and reports frame completion and short-frame errors.

Parameters:
DW, 12, pixel data width (RGB444)
WIDTH, 640, pixels per line
HEIGHT, 480, lines per frame
AW, 19, write address width; must satisfy 2^AW >= WIDTH*HEIGHT

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_mode  in  2  00=stop, 01=continuous, 10=single, 11=treated as stop
i_snap  in  1  one-cycle snapshot request; sampled in IDLE only
i_data_valid  in  1  upstream beat valid
i_sof  in  1  start-of-frame flag; meaningful only when i_data_valid=1
i_data  in  DW  upstream pixel
o_data_ready  out  1  upstream ready
o_wr_en  out  1  frame-buffer write enable
o_wr_addr  out  AW  frame-buffer write address
o_wr_data  out  DW  frame-buffer write data
o_busy  out  1  high in WAIT_SOF or CAPTURE
o_frame_done  out  1  one-cycle pulse when the last pixel of a frame is written
o_err_short  out  1  one-cycle pulse when SOF arrives mid-frame
o_frame_cnt  out  8  completed frames, wraps 255->0

Behaviour:
- Clock and reset: single clock i_clk; reset is synchronous and active-high on i_rst.
- All outputs are registered. On reset all outputs are 0, state=IDLE, address counter=0.
- o_data_ready:
  - 0 during reset and 1 from the first cycle after i_rst deasserts.
  - Beats are never back-pressured. Beats not captured are accepted and discarded, so upstream never stalls.
- Accepted beat: i_data_valid & o_data_ready.
- Write latency: an accepted, captured beat drives o_wr_en=1 with its o_wr_addr/o_wr_data exactly 1 cycle later. o_wr_en=0 in all other cycles.
- Address order: linear row-major, 0 .. WIDTH*HEIGHT-1.
- IDLE:
  - Accepted beats are discarded.
  - If mode=01, go to WAIT_SOF.
  - If mode=10 and i_snap=1, go to WAIT_SOF.
  - i_snap in any other state or mode is ignored (not queued).
- WAIT_SOF:
  - Beats without i_sof are discarded.
  - An accepted beat with i_sof=1 is written at address 0; the counter becomes 1 and the state goes to CAPTURE.
  - If mode becomes 00 or 11 with no SOF beat in that cycle, return to IDLE immediately.
- CAPTURE:
  - Each accepted beat with i_sof=0 is written at the counter value; the counter then increments.
  - Mode changes in CAPTURE take effect only at the frame boundary; frames are never truncated by mode change.
- End of frame (beat written at WIDTH*HEIGHT-1):
  - o_frame_done pulses in the same cycle as that write (o_wr_en).
  - o_frame_cnt increments.
  - The counter returns to 0.
  - Next state: WAIT_SOF if the mode sampled at that beat is 01, else IDLE. A single snapshot therefore returns to IDLE.
- SOF in CAPTURE at a counter other than 0:
  - o_err_short pulses with the write.
  - The beat is written at address 0 and the counter becomes 1.
  - The state stays CAPTURE; the frame restarts and o_frame_cnt is unchanged.
- SOF on the final beat of a frame: treated as a short-frame restart. o_err_short pulses, the beat is written at 0, and no frame_done is issued.
- Beats after frame_done with no SOF: discarded in WAIT_SOF or IDLE; no wrap-around writes ever occur.
- Reset mid-frame: the next cycle shows all outputs 0, no write is issued for the beat presented during reset, and the state is IDLE.
- Simultaneous events:
  - i_snap together with mode=01 in IDLE goes to WAIT_SOF (the same outcome).
  - A SOF beat in the same cycle that mode drops to 00 in WAIT_SOF is captured, and the state goes to CAPTURE.

Test Plan:
- WIDTH=4, HEIGHT=2, mode=01, two SOF-aligned frames of 8 beats (data 0x100..0x107) -> 16 writes with addresses 0..7,0..7; o_frame_done pulses twice, aligned with the address-7 writes; o_frame_cnt=2.
- mode=10, beats streamed before i_snap -> no writes. After i_snap, 3 junk beats then a SOF frame -> 8 writes at addresses 0..7, then IDLE with o_busy=0. A following frame produces no writes.
- mode=01, SOF reasserted at the 5th beat -> o_err_short pulses with a write at address 0; addresses continue 1..7 and o_frame_done arrives after 8 further beats; o_frame_cnt +1 only.
- Mode set to 00 at the 3rd beat of CAPTURE -> frame completes through address 7, then IDLE. Mode 00 in WAIT_SOF -> IDLE the next cycle with no writes.
- Gapped valid (valid every other cycle) -> each write comes 1 cycle after its beat; addresses stay contiguous; o_data_ready stays 1.
- i_rst asserted at address 4 -> next cycle all outputs 0. After release with mode=01, the next SOF frame writes from address 0, and o_frame_cnt restarts from 0.
